// File: rtl/mem_stage_pipeline.sv
// MEM stage of the 5-stage RISC-V core.
// Holds the EX/MEM and MEM/WB pipeline registers and runs the data-memory
// request/ready handshake. Loads are byte/half selected and extended, stores
// are lane-steered, and misaligned accesses are dropped with a fault pulse.
// An access that waits too long for ready is abandoned without write-back.
module mem_stage_pipeline #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        EX_valid,
    input  logic [4:0]  EX_rd,
    input  logic        EX_regwrite,
    input  logic        EX_memread,
    input  logic        EX_memwrite,
    input  logic        EX_memtoreg,
    input  logic [2:0]  EX_funct3,
    input  logic [31:0] EX_ALU_result,
    input  logic [31:0] EX_store_data,
    output logic [4:0]  EX_MEM_rd,
    output logic        EX_MEM_regwrite,
    output logic        EX_MEM_memread,
    output logic        EX_MEM_memtoreg,
    output logic [31:0] EX_MEM_ALU_result,
    output logic [4:0]  MEM_WB_rd,
    output logic        MEM_WB_regwrite,
    output logic [31:0] MEM_WB_result,
    output logic        MEM_busy,
    output logic        MEM_fault,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACCESS = 1'b1} state_e;

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    // Store lane steering: returns {wstrb, wdata}.
    function automatic logic [35:0] store_lanes(input logic [2:0] f3,
                                                input logic [1:0] a,
                                                input logic [31:0] d);
        logic [35:0] r;
        case (f3[1:0])
            2'b00:   r = {4'b0001 << a, {4{d[7:0]}}};
            2'b01:   r = {4'b0011 << {a[1], 1'b0}, {2{d[15:0]}}};
            default: r = {4'b1111, d};
        endcase
        return r;
    endfunction

    // Load byte/half selection with sign or zero extension.
    function automatic logic [31:0] load_extend(input logic [2:0] f3,
                                                input logic [1:0] a,
                                                input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, fault_q;
    logic [4:0]  ex_mem_rd_q;
    logic        ex_mem_regwrite_q, ex_mem_memread_q, ex_mem_memwrite_q, ex_mem_memtoreg_q;
    logic [2:0]  ex_mem_funct3_q;
    logic [31:0] ex_mem_alu_q;
    logic        dmem_we_q;
    logic [31:0] dmem_addr_q, dmem_wdata_q;
    logic [3:0]  dmem_wstrb_q;
    logic [4:0]  mem_wb_rd_q;
    logic        mem_wb_regwrite_q;
    logic [31:0] mem_wb_result_q;

    logic        misalign_s, rd_nz_s, ok_s;
    logic        cap_regwrite_s, cap_memread_s, cap_memwrite_s, cap_memtoreg_s;
    logic        start_s, in_access_s, timeout_s, busy_s, advance_s;
    logic [35:0] lanes_s;

    // Capture qualification: alignment, x0 suppression, access start.
    always_comb begin
        misalign_s = 1'b0;
        if (EX_valid && (EX_memread || EX_memwrite)) begin
            case (EX_funct3)
                3'b001, 3'b101: misalign_s = EX_ALU_result[0];
                3'b010:         misalign_s = (EX_ALU_result[1:0] != 2'b00);
                default:        misalign_s = 1'b0;
            endcase
        end else begin
            misalign_s = 1'b0;
        end
        rd_nz_s        = (EX_rd != 5'd0);
        ok_s           = EX_valid && !misalign_s;
        cap_regwrite_s = ok_s && EX_regwrite && rd_nz_s;
        cap_memread_s  = ok_s && EX_memread && rd_nz_s;
        cap_memtoreg_s = ok_s && EX_memtoreg && rd_nz_s;
        cap_memwrite_s = ok_s && EX_memwrite;
        start_s        = cap_memread_s || cap_memwrite_s;
        lanes_s        = store_lanes(EX_funct3, EX_ALU_result[1:0], EX_store_data);
    end

    // Handshake status: an access is abandoned once the wait counter hits the limit.
    always_comb begin
        in_access_s = (state_q == ST_ACCESS);
        timeout_s   = in_access_s && !dmem_ready && (cnt_q >= TIMEOUT_LIM);
        busy_s      = in_access_s && !dmem_ready && !timeout_s;
        advance_s   = !busy_s;
    end

    // Next state and wait counter for the memory handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d = ST_ACCESS;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = cnt_q;
                end
            end
            ST_ACCESS: begin
                if (dmem_ready || timeout_s) begin
                    state_d = start_s ? ST_ACCESS : ST_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = ST_ACCESS;
                    cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // FSM state, counter, registered request and fault pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            req_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= (state_d == ST_ACCESS);
            fault_q <= (advance_s && misalign_s) || timeout_s;
        end
    end

    // EX/MEM register and memory request fields; a bubble clears control only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_mem_rd_q       <= 5'd0;
            ex_mem_regwrite_q <= 1'b0;
            ex_mem_memread_q  <= 1'b0;
            ex_mem_memwrite_q <= 1'b0;
            ex_mem_memtoreg_q <= 1'b0;
            ex_mem_funct3_q   <= 3'd0;
            ex_mem_alu_q      <= 32'd0;
            dmem_we_q         <= 1'b0;
            dmem_addr_q       <= 32'd0;
            dmem_wdata_q      <= 32'd0;
            dmem_wstrb_q      <= 4'd0;
        end else if (advance_s) begin
            ex_mem_regwrite_q <= cap_regwrite_s;
            ex_mem_memread_q  <= cap_memread_s;
            ex_mem_memwrite_q <= cap_memwrite_s;
            ex_mem_memtoreg_q <= cap_memtoreg_s;
            dmem_we_q         <= cap_memwrite_s;
            dmem_wstrb_q      <= cap_memwrite_s ? lanes_s[35:32] : 4'd0;
            if (EX_valid) begin
                ex_mem_rd_q     <= EX_rd;
                ex_mem_funct3_q <= EX_funct3;
                ex_mem_alu_q    <= EX_ALU_result;
                dmem_addr_q     <= {EX_ALU_result[31:2], 2'b00};
                dmem_wdata_q    <= lanes_s[31:0];
            end
        end
    end

    // MEM/WB register: write back when the MEM instruction leaves, bubble while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wb_rd_q       <= 5'd0;
            mem_wb_regwrite_q <= 1'b0;
            mem_wb_result_q   <= 32'd0;
        end else if (advance_s) begin
            mem_wb_rd_q       <= ex_mem_rd_q;
            mem_wb_regwrite_q <= ex_mem_regwrite_q && !timeout_s;
            mem_wb_result_q   <= ex_mem_memtoreg_q
                                 ? load_extend(ex_mem_funct3_q, ex_mem_alu_q[1:0], dmem_rdata)
                                 : ex_mem_alu_q;
        end else begin
            mem_wb_regwrite_q <= 1'b0;
        end
    end

    assign EX_MEM_rd         = ex_mem_rd_q;
    assign EX_MEM_regwrite   = ex_mem_regwrite_q;
    assign EX_MEM_memread    = ex_mem_memread_q;
    assign EX_MEM_memtoreg   = ex_mem_memtoreg_q;
    assign EX_MEM_ALU_result = ex_mem_alu_q;
    assign MEM_WB_rd         = mem_wb_rd_q;
    assign MEM_WB_regwrite   = mem_wb_regwrite_q;
    assign MEM_WB_result     = mem_wb_result_q;
    assign MEM_busy          = busy_s;
    assign MEM_fault         = fault_q;
    assign dmem_req          = req_q;
    assign dmem_we           = dmem_we_q;
    assign dmem_addr         = dmem_addr_q;
    assign dmem_wdata        = dmem_wdata_q;
    assign dmem_wstrb        = dmem_wstrb_q;

endmodule

// File: tb/tb_mem_stage_pipeline.sv
// Scoreboard bench for mem_stage_pipeline: stimulus pushes expected write-backs
// and memory transactions; monitors pop and compare when the DUT presents them.
module tb_mem_stage_pipeline;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        EX_valid;
    logic [4:0]  EX_rd;
    logic        EX_regwrite, EX_memread, EX_memwrite, EX_memtoreg;
    logic [2:0]  EX_funct3;
    logic [31:0] EX_ALU_result, EX_store_data;
    logic [4:0]  EX_MEM_rd;
    logic        EX_MEM_regwrite, EX_MEM_memread, EX_MEM_memtoreg;
    logic [31:0] EX_MEM_ALU_result;
    logic [4:0]  MEM_WB_rd;
    logic        MEM_WB_regwrite;
    logic [31:0] MEM_WB_result;
    logic        MEM_busy, MEM_fault;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    mem_stage_pipeline #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .EX_valid(EX_valid), .EX_rd(EX_rd), .EX_regwrite(EX_regwrite),
        .EX_memread(EX_memread), .EX_memwrite(EX_memwrite), .EX_memtoreg(EX_memtoreg),
        .EX_funct3(EX_funct3), .EX_ALU_result(EX_ALU_result), .EX_store_data(EX_store_data),
        .EX_MEM_rd(EX_MEM_rd), .EX_MEM_regwrite(EX_MEM_regwrite),
        .EX_MEM_memread(EX_MEM_memread), .EX_MEM_memtoreg(EX_MEM_memtoreg),
        .EX_MEM_ALU_result(EX_MEM_ALU_result),
        .MEM_WB_rd(MEM_WB_rd), .MEM_WB_regwrite(MEM_WB_regwrite), .MEM_WB_result(MEM_WB_result),
        .MEM_busy(MEM_busy), .MEM_fault(MEM_fault),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [4:0] rd; logic [31:0] res; } wb_t;
    typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } mt_t;

    wb_t wb_q[$];
    mt_t mt_q[$];
    int  n_chk = 0;
    int  n_fail = 0;
    int  busy_cnt = 0;
    int  fault_cnt = 0;
    int  req_cnt = 0;
    int  mem_wait = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory responder: ready after mem_wait cycles of request.
    initial begin
        int wcnt;
        wcnt = 0;
        dmem_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!dmem_req) begin
                wcnt = 0;
                dmem_ready = 1'b0;
            end else if (wcnt >= mem_wait) begin
                wcnt = 0;
                dmem_ready = 1'b1;
            end else begin
                wcnt++;
                dmem_ready = 1'b0;
            end
        end
    end

    // Monitor: counts status cycles and scores write-backs and completed accesses.
    initial begin
        wb_t e;
        mt_t m;
        forever begin
            @(negedge clk);
            #1;
            if (MEM_busy)  busy_cnt++;
            if (MEM_fault) fault_cnt++;
            if (dmem_req)  req_cnt++;
            if (MEM_WB_regwrite) begin
                if (wb_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL wb_unexpected: got rd=%0d res=%h expected none", MEM_WB_rd, MEM_WB_result);
                end else begin
                    e = wb_q.pop_front();
                    check("wb_rd", {27'd0, MEM_WB_rd}, {27'd0, e.rd});
                    check("wb_result", MEM_WB_result, e.res);
                end
            end
            if (dmem_req && dmem_ready) begin
                if (mt_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL mem_unexpected: got addr=%h we=%b expected none", dmem_addr, dmem_we);
                end else begin
                    m = mt_q.pop_front();
                    check("mem_we", {31'd0, dmem_we}, {31'd0, m.we});
                    check("mem_addr", dmem_addr, m.addr);
                    check("mem_wstrb", {28'd0, dmem_wstrb}, {28'd0, m.wstrb});
                    if (m.we) check("mem_wdata", dmem_wdata, m.wdata);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one instruction and hold it until an edge with MEM_busy low captures it.
    task automatic issue(input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                         input logic mtr, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] sd);
        int k;
        EX_valid = 1'b1; EX_rd = rd; EX_regwrite = rw; EX_memread = mr;
        EX_memwrite = mw; EX_memtoreg = mtr; EX_funct3 = f3;
        EX_ALU_result = alu; EX_store_data = sd;
        k = 0;
        do begin
            @(negedge clk);
            #2;
            k++;
        end while (MEM_busy && k < 64);
        if (MEM_busy) begin
            n_chk++; n_fail++;
            $display("FAIL issue_timeout: got busy=1 expected capture within 64 cycles");
        end
        @(posedge clk);
        #1;
        EX_valid = 1'b0;
    endtask

    initial begin
        int b0, f0, r0;
        rst_n = 1'b0; EX_valid = 1'b0; EX_rd = 5'd0; EX_regwrite = 1'b0;
        EX_memread = 1'b0; EX_memwrite = 1'b0; EX_memtoreg = 1'b0;
        EX_funct3 = 3'd0; EX_ALU_result = 32'd0; EX_store_data = 32'd0;
        dmem_rdata = 32'd0;
        #2;
        check("reset_ctrl", {23'd0, EX_MEM_rd, EX_MEM_regwrite, MEM_WB_regwrite, MEM_busy, MEM_fault},
              32'd0);
        check("reset_req", {28'd0, dmem_req, dmem_we, 2'b00}, 32'd0);
        check("reset_wb_result", MEM_WB_result, 32'd0);
        check("reset_addr", dmem_addr, 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // ADD rd=5
        wb_q.push_back('{rd: 5'd5, res: 32'h0000_0010});
        issue(5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0000_0010, 32'd0);
        @(negedge clk); #2;
        check("add_exmem_rd", {27'd0, EX_MEM_rd}, 32'd5);
        check("add_exmem_rw", {31'd0, EX_MEM_regwrite}, 32'd1);
        check("add_exmem_alu", EX_MEM_ALU_result, 32'h0000_0010);
        idle(2);

        // ADD rd=0: x0 never forwarded
        issue(5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'd0);
        @(negedge clk); #2;
        check("x0_exmem_rw", {31'd0, EX_MEM_regwrite}, 32'd0);
        idle(2);

        // LB with 2 wait cycles, then LBU
        mem_wait = 2; dmem_rdata = 32'h80FF_FFFF; b0 = busy_cnt;
        wb_q.push_back('{rd: 5'd3, res: 32'hFFFF_FF80});
        mt_q.push_back('{we: 1'b0, addr: 32'h0000_0100, wdata: 32'd0, wstrb: 4'b0000});
        issue(5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'd0);
        @(negedge clk); #2;
        check("lb_addr", dmem_addr, 32'h0000_0100);
        check("lb_req", {31'd0, dmem_req}, 32'd1);
        idle(5);
        check("lb_busy_cycles", busy_cnt - b0, 32'd2);
        wb_q.push_back('{rd: 5'd3, res: 32'h0000_0080});
        mt_q.push_back('{we: 1'b0, addr: 32'h0000_0100, wdata: 32'd0, wstrb: 4'b0000});
        issue(5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 3'b100, 32'h0000_0103, 32'd0);
        idle(5);

        // LH / LHU upper half
        mem_wait = 0; dmem_rdata = 32'h8001_0000;
        wb_q.push_back('{rd: 5'd4, res: 32'hFFFF_8001});
        mt_q.push_back('{we: 1'b0, addr: 32'h0000_0600, wdata: 32'd0, wstrb: 4'b0000});
        issue(5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_0602, 32'd0);
        wb_q.push_back('{rd: 5'd6, res: 32'h0000_8001});
        mt_q.push_back('{we: 1'b0, addr: 32'h0000_0600, wdata: 32'd0, wstrb: 4'b0000});
        issue(5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 3'b101, 32'h0000_0602, 32'd0);
        idle(3);

        // SH 0x202, one wait cycle
        mem_wait = 1;
        mt_q.push_back('{we: 1'b1, addr: 32'h0000_0200, wdata: 32'hBEEF_BEEF, wstrb: 4'b1100});
        issue(5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0000_BEEF);
        @(negedge clk); #2;
        check("sh_we", {31'd0, dmem_we}, 32'd1);
        check("sh_wstrb", {28'd0, dmem_wstrb}, 32'h0000_000C);
        check("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
        idle(4);

        // SB 0x701 and SW 0x800
        mem_wait = 0;
        mt_q.push_back('{we: 1'b1, addr: 32'h0000_0700, wdata: 32'hA5A5_A5A5, wstrb: 4'b0010});
        issue(5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h0000_0701, 32'h1234_56A5);
        mt_q.push_back('{we: 1'b1, addr: 32'h0000_0800, wdata: 32'hDEAD_BEEF, wstrb: 4'b1111});
        issue(5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_0800, 32'hDEAD_BEEF);
        idle(3);

        // Misaligned LW 0x301
        f0 = fault_cnt;
        issue(5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0301, 32'd0);
        @(negedge clk); #2;
        check("mis_req", {31'd0, dmem_req}, 32'd0);
        check("mis_fault", {31'd0, MEM_fault}, 32'd1);
        check("mis_exmem_memread", {31'd0, EX_MEM_memread}, 32'd0);
        idle(3);
        check("mis_fault_pulses", fault_cnt - f0, 32'd1);

        // Timeout with TIMEOUT_CYCLES=4
        mem_wait = 255; b0 = busy_cnt; f0 = fault_cnt;
        issue(5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0400, 32'd0);
        idle(8);
        check("to_busy_cycles", busy_cnt - b0, 32'd4);
        check("to_fault_pulses", fault_cnt - f0, 32'd1);
        check("to_req_idle", {31'd0, dmem_req}, 32'd0);

        // Back-to-back LW/LW, ready every cycle
        mem_wait = 0; dmem_rdata = 32'h1234_5678; b0 = busy_cnt; r0 = req_cnt;
        wb_q.push_back('{rd: 5'd10, res: 32'h1234_5678});
        mt_q.push_back('{we: 1'b0, addr: 32'h0000_0500, wdata: 32'd0, wstrb: 4'b0000});
        wb_q.push_back('{rd: 5'd11, res: 32'h1234_5678});
        mt_q.push_back('{we: 1'b0, addr: 32'h0000_0504, wdata: 32'd0, wstrb: 4'b0000});
        issue(5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0500, 32'd0);
        issue(5'd11, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0504, 32'd0);
        idle(3);
        check("b2b_busy_cycles", busy_cnt - b0, 32'd0);
        check("b2b_req_cycles", req_cnt - r0, 32'd2);

        // Async reset in the middle of an access
        mem_wait = 255;
        issue(5'd12, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0900, 32'd0);
        @(negedge clk); #2;
        check("rst_pre_busy", {31'd0, MEM_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctrl", {23'd0, EX_MEM_rd, EX_MEM_regwrite, MEM_WB_regwrite, MEM_busy, MEM_fault},
              32'd0);
        check("rst_mid_req", {28'd0, dmem_req, dmem_we, 2'b00}, 32'd0);
        check("rst_mid_addr", dmem_addr, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_wait = 0;
        idle(4);

        check("wb_queue_drained", wb_q.size(), 32'd0);
        check("mem_queue_drained", mt_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
